// File: rtl/dsm_pkg.sv
// Shared constants and width helpers for the delta-sigma datapath.
package dsm_pkg;

  localparam int CIC_ORDER = 3;

  // A stream bit of 1 weighs +DSM_BIT_WEIGHT, a 0 weighs -DSM_BIT_WEIGHT.
  localparam int DSM_BIT_WEIGHT = 1;

  function automatic int cic_acc_width(input int dec_log2);
    return CIC_ORDER * dec_log2 + 2;
  endfunction

  function automatic int cic_out_shift(input int dec_log2, input int out_width);
    return CIC_ORDER * dec_log2 + 1 - out_width;
  endfunction

endpackage

// File: rtl/dsm_cic_decimator_if.sv
// Bit-stream input and PCM output bundle of the CIC decimator.
interface dsm_cic_decimator_if #(
  parameter int OUT_WIDTH = 16
);
  logic                        clk_en;
  logic                        dsm_in;
  logic signed [OUT_WIDTH-1:0] pcm_out;
  logic                        pcm_valid;

  modport master (output clk_en, output dsm_in, input pcm_out, input pcm_valid);
  modport slave  (input clk_en, input dsm_in, output pcm_out, output pcm_valid);
endinterface

// File: rtl/dsm_cic_comb.sv
// One CIC differentiator stage: out = in - previous in, advanced by valid_in.
module dsm_cic_comb #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [ACC_W-1:0] data_in,
  output logic             valid_out,
  output logic [ACC_W-1:0] data_out
);
  logic [ACC_W-1:0] dly_q, dly_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             vld_q, vld_d;

  always_comb begin
    dly_d = dly_q;
    out_d = out_q;
    vld_d = valid_in;
    if (valid_in) begin
      out_d = data_in - dly_q;
      dly_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign valid_out = vld_q;
  assign data_out  = out_q;
endmodule

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator turning a 1-bit DSM stream into signed PCM.
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int DEC_LOG2  = 6
) (
  input logic                 clk,
  input logic                 rst,
  dsm_cic_decimator_if.slave  bus
);
  localparam int ACC_W = cic_acc_width(DEC_LOG2);
  localparam int SH    = cic_out_shift(DEC_LOG2, OUT_WIDTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

  logic [ACC_W-1:0]    x;
  logic [ACC_W-1:0]    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [ACC_W-1:0]    samp_q, samp_d;
  logic                strobe_q, strobe_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;

  assign x = bus.dsm_in ? ACC_W'(DSM_BIT_WEIGHT) : -ACC_W'(DSM_BIT_WEIGHT);

  // Each integrator consumes the pre-edge value of the one before it.
  always_comb begin
    i1_d     = i1_q;
    i2_d     = i2_q;
    i3_d     = i3_q;
    cnt_d    = cnt_q;
    samp_d   = samp_q;
    strobe_d = 1'b0;
    if (bus.clk_en) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        samp_d   = i3_q;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
      cnt_q    <= '0;
      samp_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      i3_q     <= i3_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
      strobe_q <= strobe_d;
    end
  end

  logic [ACC_W-1:0] c1, c2, c3;
  logic             c1_vld, c2_vld, c3_vld;

  dsm_cic_comb #(.ACC_W(ACC_W)) u_comb1 (
    .clk(clk), .rst(rst), .valid_in(strobe_q), .data_in(samp_q),
    .valid_out(c1_vld), .data_out(c1)
  );
  dsm_cic_comb #(.ACC_W(ACC_W)) u_comb2 (
    .clk(clk), .rst(rst), .valid_in(c1_vld), .data_in(c1),
    .valid_out(c2_vld), .data_out(c2)
  );
  dsm_cic_comb #(.ACC_W(ACC_W)) u_comb3 (
    .clk(clk), .rst(rst), .valid_in(c2_vld), .data_in(c2),
    .valid_out(c3_vld), .data_out(c3)
  );

  // The last comb register holds between samples, so the output holds too.
  logic signed [ACC_W-1:0] shifted, sat;

  always_comb begin
    shifted = signed'(c3) >>> SH;
    sat     = shifted;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN;
    end
  end

  assign bus.pcm_out   = sat[OUT_WIDTH-1:0];
  assign bus.pcm_valid = c3_vld;
endmodule
